// File: rtl/uart_tx_if.sv
// Handshake/payload bundle between a byte source and the UART transmitter.
// master = data source, slave = uart_tx.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART frame serializer: start bit, LSB-first payload, optional parity, stop bit.
// One CLK edge per bit; back-to-back frames are accepted in the last STOP cycle.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic                  accept;

    // Requests outside IDLE/STOP are dropped, not queued.
    assign accept = bus.DATA_VALID && (state_q == IDLE || state_q == STOP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        case (state_q)
            IDLE:    if (accept) state_d = START;
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d    = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_typ_d = bus.PAR_TYP;
            cnt_d     = '0;
        end

        // Outputs are decoded from the next state so they land in flops.
        tx_out_d = 1'b1;
        busy_d   = 1'b1;
        case (state_d)
            IDLE:    busy_d   = 1'b0;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = data_d[cnt_d];
            PARITY:  tx_out_d = (^data_d) ^ par_typ_d;
            STOP:    tx_out_d = 1'b1;
            default: busy_d   = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: fixed frame table, random frames against a frame model,
// plus back-to-back, input-stability and mid-frame reset sequences.
module tb_uart_tx;
    localparam int DW = 8;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_fail;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [7:0]  d;
        bit          pen;
        bit          ptyp;
        int          len;
        logic [15:0] seq;   // first transmitted bit at seq[len-1]
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame as a list of line levels, built from the framing rules.
    function automatic void model(input logic [7:0] d, input bit pen, input bit ptyp,
                                  output logic [15:0] seq, output int len);
        logic q[$];
        int   ones;
        ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(d[i]);
        if (pen) q.push_back(((ones + int'(ptyp)) % 2) == 1);
        q.push_back(1'b1);
        len = q.size();
        seq = '0;
        for (int i = 0; i < len; i++) seq[len-1-i] = q[i];
    endfunction

    // Entered at posedge+1 with the line idle; returns at posedge+1 idle.
    task automatic run_frame(input string nm, input logic [7:0] d, input bit pen,
                             input bit ptyp, input int len, input logic [15:0] seq);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.DATA_VALID = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge CLK); #1;
            if (i == 0) begin
                bus.DATA_VALID = 1'b0;
                bus.P_DATA     = ~d;
                bus.PAR_EN     = ~pen;
                bus.PAR_TYP    = ~ptyp;
            end
            chk($sformatf("%s bit%0d tx", nm, i), 32'(bus.TX_OUT), 32'(seq[len-1-i]));
            chk($sformatf("%s bit%0d busy", nm, i), 32'(bus.Busy), 32'd1);
        end
        @(posedge CLK); #1;
        chk({nm, " idle tx"}, 32'(bus.TX_OUT), 32'd1);
        chk({nm, " idle busy"}, 32'(bus.Busy), 32'd0);
    endtask

    vec_t        vt[3];
    logic [15:0] s1, s2;
    int          l1, l2;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        RST = 1'b0;

        vt[0] = '{"even_a5", 8'hA5, 1'b1, 1'b0, 11, 16'({11'b0_10100101_0_1})};
        vt[1] = '{"odd_a5",  8'hA5, 1'b1, 1'b1, 11, 16'({11'b0_10100101_1_1})};
        vt[2] = '{"nopar_3c", 8'h3C, 1'b0, 1'b0, 10, 16'({10'b0_00111100_1})};

        #12;
        chk("reset tx", 32'(bus.TX_OUT), 32'd1);
        chk("reset busy", 32'(bus.Busy), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;

        foreach (vt[k]) run_frame(vt[k].name, vt[k].d, vt[k].pen, vt[k].ptyp, vt[k].len, vt[k].seq);

        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            bit pen, ptyp;
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            model(d, pen, ptyp, s1, l1);
            run_frame($sformatf("rand%0d", r), d, pen, ptyp, l1, s1);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #0;
        end

        // Back-to-back: DATA_VALID held, payload switched in the first STOP cycle.
        model(8'hFF, 1'b1, 1'b0, s1, l1);
        model(8'h00, 1'b1, 1'b0, s2, l2);
        bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
        for (int i = 0; i < l1 + l2; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("b2b bit%0d tx", i), 32'(bus.TX_OUT),
                32'((i < l1) ? s1[l1-1-i] : s2[l2-1-(i-l1)]));
            chk($sformatf("b2b bit%0d busy", i), 32'(bus.Busy), 32'd1);
            if (i == l1 - 1) bus.P_DATA = 8'h00;
            if (i == l1) bus.DATA_VALID = 1'b0;
        end
        @(posedge CLK); #1;
        chk("b2b idle tx", 32'(bus.TX_OUT), 32'd1);
        chk("b2b idle busy", 32'(bus.Busy), 32'd0);

        // Payload change mid-frame and a stray request during DATA are both ignored.
        model(8'h5A, 1'b0, 1'b0, s1, l1);
        bus.P_DATA = 8'h5A; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
        for (int i = 0; i < l1 + 3; i++) begin
            @(posedge CLK); #1;
            if (i == 0) bus.DATA_VALID = 1'b0;
            chk($sformatf("stab bit%0d tx", i), 32'(bus.TX_OUT), 32'((i < l1) ? s1[l1-1-i] : 1'b1));
            chk($sformatf("stab bit%0d busy", i), 32'(bus.Busy), 32'(i < l1));
            if (i == 3) bus.P_DATA = 8'hFF;
            if (i == 4) bus.DATA_VALID = 1'b1;
            if (i == 5) bus.DATA_VALID = 1'b0;
        end

        // Reset during data bit 4 (frame 0x00 so the line is low when it hits).
        bus.P_DATA = 8'h00; bus.PAR_EN = 1'b1; bus.DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.DATA_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("rst pre tx", 32'(bus.TX_OUT), 32'd0);
        chk("rst pre busy", 32'(bus.Busy), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("rst async tx", 32'(bus.TX_OUT), 32'd1);
        chk("rst async busy", 32'(bus.Busy), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("post rst%0d tx", i), 32'(bus.TX_OUT), 32'd1);
            chk($sformatf("post rst%0d busy", i), 32'(bus.Busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART serializer that converts a parallel byte into a framed serial bit stream: start bit, LSB-first data, optional parity, and stop bit. It is the transmit-side counterpart of the UART_RX path and uses the same parity convention, so frames it produces pass the receiver's parity check. The block runs on the transmit bit clock, one CLK cycle per bit, and sits between the system-side data source and the TX pin.

## Interface
- DATA_WIDTH, default 8: payload bits per frame.
- CLK  in  1  transmit bit clock; one bit period per rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel payload; sampled only on accept.
- DATA_VALID  in  1  request to send P_DATA; single-cycle pulse or held level.
- PAR_EN  in  1  1 = insert parity bit; sampled on accept.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled on accept.
- TX_OUT  out  1  serial line, idle high; registered.
- Busy  out  1  high while a frame is on the line; registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition:
  - DATA_VALID = 1 at a rising edge while in IDLE, or in the last STOP cycle.
  - On accept, latch P_DATA, PAR_EN and PAR_TYP into internal registers.
  - Input changes after accept have no effect on the current frame.
- IDLE -> START on accept; otherwise stay in IDLE with TX_OUT = 1 and Busy = 0.
- START: TX_OUT = 0. Next state is DATA with bit counter = 0.
- DATA: TX_OUT = latched data[counter], LSB first.
  - Counter increments each cycle.
  - At counter = DATA_WIDTH-1, go to PARITY if the latched PAR_EN = 1, else to STOP.
  - Counter width is clog2(DATA_WIDTH); it clears on entry to START.
- PARITY: TX_OUT = XOR-reduce(latched data) XOR latched PAR_TYP.
  - Even parity: total count of 1s including the parity bit is even.
  - Odd parity: that total is odd.
- STOP: TX_OUT = 1.
  - Next state is START if DATA_VALID = 1 at this edge (back-to-back frame, no idle gap).
  - Otherwise next state is IDLE.
- Busy = 1 in START, DATA, PARITY and STOP; Busy = 0 in IDLE.
- DATA_VALID in START, DATA or PARITY is ignored. It is not queued; the source must hold it or re-assert it.

## Timing
- Reset (async assert): state = IDLE, TX_OUT = 1, Busy = 0, counter = 0, latched data/config = 0.
  - Reset mid-frame aborts the frame immediately, and the line returns high without waiting for a clock edge.
  - After RST is released, the first accept can occur on the first rising edge.
- Let accept happen at edge k. Then:
  - After edge k: TX_OUT = 0 (start bit) and Busy = 1. Latency from request to start bit is one edge.
  - Data bit i is driven after edge k+1+i, for i = 0..DATA_WIDTH-1.
  - Parity bit (if enabled) is driven after edge k+1+DATA_WIDTH.
  - Stop bit is driven after edge k+1+DATA_WIDTH+PAR_EN.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity. For DATA_WIDTH = 8 that is 10 or 11 cycles.
- At the edge ending STOP:
  - If DATA_VALID = 0: TX_OUT = 1 and Busy = 0 from that edge.
  - If DATA_VALID = 1: TX_OUT = 0 and Busy stays 1 with no low glitch.
- All outputs are flop outputs; there are no combinational paths from inputs to outputs.

## Test plan
- Even parity: reset, then P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, pulse DATA_VALID for one cycle.
  - Required TX_OUT sequence: 0, 1,0,1,0,0,1,0,1, 0, 1, then idle 1.
  - Busy is high for exactly 11 cycles.
- Odd parity: same frame with PAR_TYP = 1. The parity bit must be 1; all other bits are identical to the even-parity case.
- No parity: P_DATA = 0x3C, PAR_EN = 0.
  - Required sequence: 0, 0,0,1,1,1,1,0,0, 1.
  - Busy is high for 10 cycles, and no parity slot appears.
- Back-to-back: DATA_VALID held high with P_DATA = 0xFF, then switched to 0x00 during the first frame's STOP cycle (PAR_EN = 1, PAR_TYP = 0).
  - First frame: 0, eight 1s, 0, 1.
  - Second frame follows with no gap: 0, eight 0s, 0, 1.
  - Busy never drops between the two frames.
- Input stability and ignored requests: change P_DATA from 0x5A to 0xFF at data bit 2, and pulse DATA_VALID during DATA.
  - The transmitted payload remains 0x5A.
  - No extra frame follows.
- Reset mid-frame: assert RST during data bit 4.
  - TX_OUT = 1 and Busy = 0 immediately (asynchronous).
  - After release with DATA_VALID = 0, the line stays idle high.
